xy_input_conditioner: RTL and testbench

- Upstream conditioning stage for the two-input, 2-bit-state FSM exercise designs.
- Takes raw asynchronous x and y (push-buttons or switches) and synchronises each to clk.
- Debounces each channel independently and drives clean x_out/y_out straight into the FSM's x/y inputs.
- Also emits single-cycle edge pulses for bench observation and downstream counting.

---
 rtl/xy_input_conditioner.sv | 172 +++++++++++++++++
 tb/tb_xy_input_conditioner.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xy_input_conditioner.sv
// Synchronise, debounce and edge-detect the raw x/y inputs feeding the two-input FSM exercises.
// Each channel commits a new level only after DEBOUNCE_CYCLES consecutive agreeing samples.

module xy_debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic raw,
  input  logic en,
  output logic level,
  output logic rise,
  output logic fall,
  output logic commit
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] STABLE_LO = 2'd0;
  localparam logic [1:0] WAIT_HI   = 2'd1;
  localparam logic [1:0] STABLE_HI = 2'd2;
  localparam logic [1:0] WAIT_LO   = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   committed;
  logic                   level_d;

  // Synchroniser keeps sampling regardless of en.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign s         = sync_q[SYNC_STAGES-1];
  assign committed = (state_q == STABLE_HI) || (state_q == WAIT_LO);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      STABLE_LO, STABLE_HI: begin
        if (s != committed) begin
          if (DEBOUNCE_CYCLES == 1) begin
            commit = 1'b1;
          end else begin
            state_d = committed ? WAIT_LO : WAIT_HI;
            cnt_d   = CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HI, WAIT_LO: begin
        if (s != committed) begin
          if (cnt_q == CNT_LAST) begin
            commit = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // A glitch shorter than the debounce window is simply forgotten.
          state_d = committed ? STABLE_HI : STABLE_LO;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
    if (commit) begin
      state_d = committed ? STABLE_LO : STABLE_HI;
      cnt_d   = '0;
    end
    if (!en) begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
    end
  end

  assign level_d = (state_d == STABLE_HI) || (state_d == WAIT_LO);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
      rise    <= commit & ~committed;
      fall    <= commit & committed;
    end
  end

endmodule

module xy_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic x_raw,
  input  logic y_raw,
  input  logic en,
  output logic x_out,
  output logic y_out,
  output logic x_rise,
  output logic x_fall,
  output logic y_rise,
  output logic y_fall,
  output logic changed
);

  logic x_commit;
  logic y_commit;

  xy_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_x (
    .clk    (clk),
    .rst_b  (rst_b),
    .raw    (x_raw),
    .en     (en),
    .level  (x_out),
    .rise   (x_rise),
    .fall   (x_fall),
    .commit (x_commit)
  );

  xy_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_y (
    .clk    (clk),
    .rst_b  (rst_b),
    .raw    (y_raw),
    .en     (en),
    .level  (y_out),
    .rise   (y_rise),
    .fall   (y_fall),
    .commit (y_commit)
  );

  // Registered alongside the per-channel pulses so all five line up.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      changed <= 1'b0;
    end else begin
      changed <= x_commit | y_commit;
    end
  end

endmodule

// File: tb/tb_xy_input_conditioner.sv
// Bench for xy_input_conditioner: a default instance (4/2) and a fast one (1/3),
// directed vectors plus random stimulus checked against a run-length reference model.

module tb_xy_input_conditioner;

  logic clk;
  logic rst_b;
  logic x_a, y_a, en_a;
  logic x_b, y_b, en_b;
  logic xo_a, yo_a, xr_a, xf_a, yr_a, yf_a, ch_a;
  logic xo_b, yo_b, xr_b, xf_b, yr_b, yf_b, ch_b;

  int tests;
  int failures;

  xy_input_conditioner #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_b(rst_b), .x_raw(x_a), .y_raw(y_a), .en(en_a),
    .x_out(xo_a), .y_out(yo_a), .x_rise(xr_a), .x_fall(xf_a),
    .y_rise(yr_a), .y_fall(yf_a), .changed(ch_a)
  );

  xy_input_conditioner #(.DEBOUNCE_CYCLES(1), .SYNC_STAGES(3)) dut_b (
    .clk(clk), .rst_b(rst_b), .x_raw(x_b), .y_raw(y_b), .en(en_b),
    .x_out(xo_b), .y_out(yo_b), .x_rise(xr_b), .x_fall(xf_b),
    .y_rise(yr_b), .y_fall(yf_b), .changed(ch_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a channel flips once it has seen 'dc' consecutive enabled
  // edges where the synchronised input disagrees with the committed level.
  typedef struct {
    int       run;
    bit       lvl;
    bit       rise;
    bit       fall;
    bit [7:0] hist;
  } chan_m_t;

  chan_m_t m[2][2];
  bit      m_changed[2];

  task automatic chan_step(input int d, input int c, input int dc, input int ss,
                           input bit enable, input bit raw);
    bit s;
    s = m[d][c].hist[ss-1];
    m[d][c].hist = {m[d][c].hist[6:0], raw};
    m[d][c].rise = 1'b0;
    m[d][c].fall = 1'b0;
    if (enable) begin
      if (s != m[d][c].lvl) begin
        m[d][c].run = m[d][c].run + 1;
        if (m[d][c].run >= dc) begin
          m[d][c].lvl = !m[d][c].lvl;
          m[d][c].run = 0;
          if (m[d][c].lvl) m[d][c].rise = 1'b1;
          else             m[d][c].fall = 1'b1;
        end
      end else begin
        m[d][c].run = 0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 2; c++) begin
          m[d][c].run  = 0;
          m[d][c].lvl  = 1'b0;
          m[d][c].rise = 1'b0;
          m[d][c].fall = 1'b0;
          m[d][c].hist = '0;
        end
        m_changed[d] = 1'b0;
      end
    end else begin
      chan_step(0, 0, 4, 2, en_a, x_a);
      chan_step(0, 1, 4, 2, en_a, y_a);
      chan_step(1, 0, 1, 3, en_b, x_b);
      chan_step(1, 1, 1, 3, en_b, y_b);
      for (int d = 0; d < 2; d++)
        m_changed[d] = m[d][0].rise | m[d][0].fall | m[d][1].rise | m[d][1].fall;
    end
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_output();
    check_bit("A x_out",   xo_a, m[0][0].lvl);
    check_bit("A y_out",   yo_a, m[0][1].lvl);
    check_bit("A x_rise",  xr_a, m[0][0].rise);
    check_bit("A x_fall",  xf_a, m[0][0].fall);
    check_bit("A y_rise",  yr_a, m[0][1].rise);
    check_bit("A y_fall",  yf_a, m[0][1].fall);
    check_bit("A changed", ch_a, m_changed[0]);
    check_bit("B x_out",   xo_b, m[1][0].lvl);
    check_bit("B y_out",   yo_b, m[1][1].lvl);
    check_bit("B x_rise",  xr_b, m[1][0].rise);
    check_bit("B x_fall",  xf_b, m[1][0].fall);
    check_bit("B y_rise",  yr_b, m[1][1].rise);
    check_bit("B y_fall",  yf_b, m[1][1].fall);
    check_bit("B changed", ch_b, m_changed[1]);
    check_bit("A x_rise&x_fall", xr_a & xf_a, 1'b0);
  endtask

  // Drive inputs for the next rising edge, then sample at the following falling edge.
  task automatic apply_stimulus(input bit xa, input bit ya, input bit ena,
                                input bit xb, input bit yb, input bit enb);
    x_a = xa; y_a = ya; en_a = ena;
    x_b = xb; y_b = yb; en_b = enb;
    @(negedge clk);
    check_output();
  endtask

  // Asserts reset immediately (no edge needed) and releases on a falling edge.
  task automatic do_reset();
    rst_b = 1'b0;
    #1;
    check_bit("rst A x_out",   xo_a, 1'b0);
    check_bit("rst A y_out",   yo_a, 1'b0);
    check_bit("rst A changed", ch_a, 1'b0);
    check_bit("rst B x_out",   xo_b, 1'b0);
    check_bit("rst B y_out",   yo_b, 1'b0);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  typedef struct {
    bit x; bit y; bit en;
    bit ex; bit exr; bit ey; bit chg;
  } vec_t;

  vec_t vt[8];

  initial begin
    int hold[4];
    bit lv[4];

    tests = 0;
    failures = 0;
    rst_b = 1'b1;
    x_a = 0; y_a = 0; en_a = 1;
    x_b = 0; y_b = 0; en_b = 1;

    // x held high from before edge 1: commit visible after edge 6.
    vt[0] = '{1, 0, 1, 0, 0, 0, 0};
    vt[1] = '{1, 0, 1, 0, 0, 0, 0};
    vt[2] = '{1, 0, 1, 0, 0, 0, 0};
    vt[3] = '{1, 0, 1, 0, 0, 0, 0};
    vt[4] = '{1, 0, 1, 0, 0, 0, 0};
    vt[5] = '{1, 0, 1, 1, 1, 0, 1};
    vt[6] = '{1, 0, 1, 1, 0, 0, 0};
    vt[7] = '{1, 0, 1, 1, 0, 0, 0};

    #1;
    x_a = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vt[i].x, vt[i].y, vt[i].en, 0, 0, 1);
      check_bit($sformatf("vec%0d x_out", i),  xo_a, vt[i].ex);
      check_bit($sformatf("vec%0d x_rise", i), xr_a, vt[i].exr);
      check_bit($sformatf("vec%0d y_out", i),  yo_a, vt[i].ey);
      check_bit($sformatf("vec%0d changed", i), ch_a, vt[i].chg);
    end

    // Glitch of 3 cycles is ignored; a following clean rise needs the full latency.
    x_a = 1'b0;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      apply_stimulus(k <= 3, 0, 1, 0, 0, 1);
      check_bit($sformatf("glitch e%0d x_out", k), xo_a, 1'b0);
      check_bit($sformatf("glitch e%0d x_rise", k), xr_a, 1'b0);
    end
    for (int k = 1; k <= 8; k++) begin
      apply_stimulus(1, 0, 1, 0, 0, 1);
      check_bit($sformatf("post-glitch e%0d x_out", k), xo_a, k >= 6);
      check_bit($sformatf("post-glitch e%0d x_rise", k), xr_a, k == 6);
    end

    // Simultaneous rise on x and y.
    x_a = 1'b1; y_a = 1'b1;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      apply_stimulus(1, 1, 1, 0, 0, 1);
      check_bit($sformatf("both e%0d x_out", k), xo_a, k >= 6);
      check_bit($sformatf("both e%0d y_out", k), yo_a, k >= 6);
      check_bit($sformatf("both e%0d x_rise", k), xr_a, k == 6);
      check_bit($sformatf("both e%0d y_rise", k), yr_a, k == 6);
      check_bit($sformatf("both e%0d changed", k), ch_a, k == 6);
    end

    // Fall with en low for edges 5..9: commit lands on edge 11.
    for (int k = 1; k <= 12; k++) begin
      apply_stimulus(0, 1, !(k >= 5 && k <= 9), 0, 0, 1);
      check_bit($sformatf("en e%0d x_out", k), xo_a, k < 11);
      check_bit($sformatf("en e%0d x_fall", k), xf_a, k == 11);
      check_bit($sformatf("en e%0d changed", k), ch_a, k == 11);
      check_bit($sformatf("en e%0d y_out", k), yo_a, 1'b1);
    end

    // Reset asserted mid-cycle while x is part way through WAIT_HI.
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus(1, 1, 1, 0, 0, 1);
      check_bit($sformatf("midwait e%0d x_out", k), xo_a, 1'b0);
    end
    #2;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      apply_stimulus(1, 1, 1, 0, 0, 1);
      check_bit($sformatf("after-rst e%0d x_out", k), xo_a, k >= 6);
      check_bit($sformatf("after-rst e%0d x_rise", k), xr_a, k == 6);
    end

    // Fast instance: one-cycle pulse rises after edge 4 and falls after edge 5.
    for (int k = 1; k <= 7; k++) begin
      apply_stimulus(1, 1, 1, k == 1, 0, 1);
      check_bit($sformatf("fast e%0d x_out", k), xo_b, k == 4);
      check_bit($sformatf("fast e%0d x_rise", k), xr_b, k == 4);
      check_bit($sformatf("fast e%0d x_fall", k), xf_b, k == 5);
      check_bit($sformatf("fast e%0d changed", k), ch_b, k == 4 || k == 5);
    end

    // Random levels held for 1..8 cycles, en mostly high, one reset in the middle.
    for (int j = 0; j < 4; j++) begin
      hold[j] = 0;
      lv[j] = 1'b0;
    end
    for (int n = 0; n < 600; n++) begin
      for (int j = 0; j < 4; j++) begin
        if (hold[j] == 0) begin
          lv[j] = $urandom_range(1, 0);
          hold[j] = $urandom_range(8, 1);
        end
        hold[j]--;
      end
      if (n == 300) begin
        #2;
        do_reset();
      end
      apply_stimulus(lv[0], lv[1], ($urandom % 8) != 0,
                     lv[2], lv[3], ($urandom % 6) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
